// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and a
// helper that turns an access size into a byte count.
package mem_lsu_pkg;

    typedef logic [2:0] access_sz_t;

    localparam access_sz_t ACCESS_SZ_BYTE = 3'd0;
    localparam access_sz_t ACCESS_SZ_HALF = 3'd1;
    localparam access_sz_t ACCESS_SZ_WORD = 3'd2;

    // Any encoding other than BYTE/HALF is a full word.
    function automatic logic [2:0] access_bytes(input access_sz_t sz);
        case (sz)
            ACCESS_SZ_BYTE: return 3'd1;
            ACCESS_SZ_HALF: return 3'd2;
            default:        return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Combinational load-data extraction: picks the low byte/half/word of the
// dcache read data and sign- or zero-extends it.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  access_sz_t  sz_i,
    input  logic        sext_i,
    output logic [31:0] data_o
);

    // Size-dependent extraction with optional sign extension.
    always_comb begin
        data_o = rdata_i;
        case (sz_i)
            ACCESS_SZ_BYTE: data_o = {{24{sext_i & rdata_i[7]}}, rdata_i[7:0]};
            ACCESS_SZ_HALF: data_o = {{16{sext_i & rdata_i[15]}}, rdata_i[15:0]};
            default:        data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between execute and a two-cycle-latency dcache.
// Optional macro LSU_MISALIGN_CHECK_EN makes misaligned half/word accesses fault.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32'd8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_st,
    input  logic [2:0]  in_sz,
    input  logic        in_sext,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_exc,
    output logic        dc_re,
    output logic [31:0] dc_raddr,
    output logic        dc_we,
    output logic [31:0] dc_waddr,
    output logic [31:0] dc_wdata,
    output logic [2:0]  dc_wsz,
    input  logic [31:0] dc_rdata,
    input  logic        dc_hit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        STORE = 3'd2,
        WAIT1 = 3'd3,
        WAIT2 = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    // 33-bit end address so requests near 2^32 cannot wrap into range.
    function automatic logic req_fault(input logic [31:0] addr, input access_sz_t sz);
        logic [32:0] end_addr;
        logic        flt;
        end_addr = {1'b0, addr} + {30'd0, access_bytes(sz)};
        flt      = (end_addr > MEM_LIMIT);
`ifdef LSU_MISALIGN_CHECK_EN
        flt = flt | ((sz == ACCESS_SZ_HALF) & addr[0])
                  | ((sz != ACCESS_SZ_BYTE) & (sz != ACCESS_SZ_HALF) & (addr[1:0] != 2'd0));
`endif
        return flt;
    endfunction

    state_e      state_q, state_d;
    access_sz_t  sz_q, sz_d;
    logic        sext_q, sext_d;
    logic [4:0]  rd_q, rd_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_exc_q, out_exc_d;
    logic        dc_re_q, dc_re_d;
    logic [31:0] dc_raddr_q, dc_raddr_d;
    logic        dc_we_q, dc_we_d;
    logic [31:0] dc_waddr_q, dc_waddr_d;
    logic [31:0] dc_wdata_q, dc_wdata_d;
    logic [2:0]  dc_wsz_q, dc_wsz_d;
    logic [31:0] align_data_s;

    lsu_load_align u_align (
        .rdata_i (dc_rdata),
        .sz_i    (sz_q),
        .sext_i  (sext_q),
        .data_o  (align_data_s)
    );

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        sz_d        = sz_q;
        sext_d      = sext_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_exc_d   = out_exc_q;
        dc_re_d     = 1'b0;
        dc_raddr_d  = 32'd0;
        dc_we_d     = 1'b0;
        dc_waddr_d  = 32'd0;
        dc_wdata_d  = 32'd0;
        dc_wsz_d    = 3'd0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sz_d   = in_sz;
                    sext_d = in_sext;
                    rd_d   = in_rd;
                    if (req_fault(in_addr, in_sz)) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_exc_d   = 1'b1;
                        out_data_d  = 32'd0;
                        out_rd_d    = 5'd0;
                    end else if (in_st) begin
                        state_d    = STORE;
                        dc_we_d    = 1'b1;
                        dc_waddr_d = in_addr;
                        dc_wdata_d = in_wdata;
                        dc_wsz_d   = in_sz;
                    end else begin
                        state_d    = ISSUE;
                        dc_re_d    = 1'b1;
                        dc_raddr_d = in_addr;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = WAIT1;
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                state_d     = RESP;
                out_valid_d = 1'b1;
                if (dc_hit) begin
                    out_data_d = align_data_s;
                    out_rd_d   = rd_q;
                    out_exc_d  = 1'b0;
                end else begin
                    out_data_d = 32'd0;
                    out_rd_d   = 5'd0;
                    out_exc_d  = 1'b1;
                end
            end
            STORE: begin
                state_d     = RESP;
                out_valid_d = 1'b1;
                out_data_d  = 32'd0;
                out_rd_d    = 5'd0;
                out_exc_d   = 1'b0;
            end
            RESP: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = 32'd0;
                    out_rd_d    = 5'd0;
                    out_exc_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sz_q        <= ACCESS_SZ_BYTE;
            sext_q      <= 1'b0;
            rd_q        <= 5'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_rd_q    <= 5'd0;
            out_exc_q   <= 1'b0;
            dc_re_q     <= 1'b0;
            dc_raddr_q  <= 32'd0;
            dc_we_q     <= 1'b0;
            dc_waddr_q  <= 32'd0;
            dc_wdata_q  <= 32'd0;
            dc_wsz_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            sz_q        <= sz_d;
            sext_q      <= sext_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_exc_q   <= out_exc_d;
            dc_re_q     <= dc_re_d;
            dc_raddr_q  <= dc_raddr_d;
            dc_we_q     <= dc_we_d;
            dc_waddr_q  <= dc_waddr_d;
            dc_wdata_q  <= dc_wdata_d;
            dc_wsz_q    <= dc_wsz_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_exc   = out_exc_q;
    assign dc_re     = dc_re_q;
    assign dc_raddr  = dc_raddr_q;
    assign dc_we     = dc_we_q;
    assign dc_waddr  = dc_waddr_q;
    assign dc_wdata  = dc_wdata_q;
    assign dc_wsz    = dc_wsz_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, corner sequences and a
// randomized phase against a byte-array reference model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_st, in_sext;
    logic [2:0]  in_sz;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_exc;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        dc_re, dc_we;
    logic [31:0] dc_raddr, dc_waddr, dc_wdata;
    logic [2:0]  dc_wsz;
    logic [31:0] dc_rdata;
    logic        dc_hit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_lsu #(.MEM_BYTES(8192)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_st(in_st), .in_sz(in_sz),
        .in_sext(in_sext), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_exc(out_exc),
        .dc_re(dc_re), .dc_raddr(dc_raddr), .dc_we(dc_we), .dc_waddr(dc_waddr),
        .dc_wdata(dc_wdata), .dc_wsz(dc_wsz), .dc_rdata(dc_rdata), .dc_hit(dc_hit)
    );

    // dcache model: data two cycles after dc_re, byte-addressed little-endian
    logic [7:0]  mem [8192];
    logic [7:0]  ref_mem [8192];
    logic [31:0] p1_data, rd_word;
    logic        p1_hit, hit_val;
    int re_cnt = 0, we_cnt = 0, both_err = 0;
    logic [31:0] last_raddr, last_waddr, last_wdata;
    logic [2:0]  last_wsz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dc_re) begin
            for (int k = 0; k < 4; k++)
                rd_word[8*k +: 8] = mem[(int'(dc_raddr[12:0]) + k) % 8192];
            p1_data    <= rd_word;
            p1_hit     <= hit_val;
            re_cnt     <= re_cnt + 1;
            last_raddr <= dc_raddr;
        end
        dc_rdata <= p1_data;
        dc_hit   <= p1_hit;
        if (dc_we) begin
            for (int k = 0; k < ((dc_wsz == 3'd0) ? 1 : (dc_wsz == 3'd1) ? 2 : 4); k++)
                mem[(int'(dc_waddr[12:0]) + k) % 8192] = dc_wdata[8*k +: 8];
            we_cnt     <= we_cnt + 1;
            last_waddr <= dc_waddr;
            last_wdata <= dc_wdata;
            last_wsz   <= dc_wsz;
        end
        if (dc_re && dc_we) both_err <= both_err + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic model_fault(input logic [31:0] a, input logic [2:0] sz);
        return (longint'(a) + longint'(nbytes(sz))) > 64'd8192;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz,
                                               input logic sext);
        int n = nbytes(sz);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    typedef struct {
        logic        st;
        logic [2:0]  sz;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        hit;
        logic        fault;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
    } vec_t;

    task automatic wait_ready(input string nm);
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 20) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // One complete transaction with response checks, optional stall, bus checks.
    task automatic run_req(input string nm, input vec_t v, input int stall);
        int a_cyc, lat, re0, we0;
        logic        exp_exc;
        logic [31:0] hold_data;
        exp_exc = v.fault | (!v.st & !v.hit);
        wait_ready(nm);
        re0 = re_cnt; we0 = we_cnt;
        hit_val = v.hit;
        in_st = v.st; in_sz = v.sz; in_sext = v.sext; in_addr = v.addr;
        in_wdata = v.wdata; in_rd = v.rd; in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_cyc = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = cyc - a_cyc; break; end
        end
        // measured at negedge: out_valid is then seen by the edge accept+lat+1
        chk({nm, "_latency"}, lat, v.fault ? 0 : (v.st ? 1 : 3));
        chk({nm, "_data"}, out_data, v.exp_data);
        chk({nm, "_exc"}, 32'(out_exc), 32'(exp_exc));
        chk({nm, "_rd"}, 32'(out_rd), 32'(v.exp_rd));
        hold_data = out_data;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_stall_data"}, out_data, hold_data);
            chk({nm, "_stall_inready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_released"}, 32'(out_valid), 32'd0);
        chk({nm, "_re_count"}, re_cnt - re0, (!v.st && !v.fault) ? 1 : 0);
        chk({nm, "_we_count"}, we_cnt - we0, (v.st && !v.fault) ? 1 : 0);
        if (!v.fault && !v.st) chk({nm, "_raddr"}, last_raddr, v.addr);
        if (!v.fault && v.st) begin
            chk({nm, "_waddr"}, last_waddr, v.addr);
            chk({nm, "_wdata"}, last_wdata, v.wdata);
            chk({nm, "_wsz"}, 32'(last_wsz), 32'(v.sz));
            for (int k = 0; k < nbytes(v.sz); k++) ref_mem[v.addr + k] = v.wdata[8*k +: 8];
        end
    endtask

    vec_t vecs[17];
    vec_t rv;

    initial begin
        for (int i = 0; i < 8192; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
        hit_val = 1'b1; p1_hit = 1'b1; p1_data = 32'd0;
        rst = 1'b1; in_valid = 1'b0; in_st = 1'b0; in_sz = 3'd0; in_sext = 1'b0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_exc", 32'(out_exc), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_dc_re_we", {30'd0, dc_re, dc_we}, 32'd0);
        chk("rst_dc_buses", dc_raddr | dc_waddr | dc_wdata | 32'(dc_wsz), 32'd0);
        rst = 1'b0;

        //            st    sz    sext  addr          wdata          rd    hit   fault data          rd
        vecs[0]  = '{1'b1, 3'd2, 1'b0, 32'h10,   32'h11223344, 5'd5, 1'b1, 1'b0, 32'h0,        5'd0};
        vecs[1]  = '{1'b0, 3'd2, 1'b0, 32'h10,   32'h0,        5'd5, 1'b1, 1'b0, 32'h11223344, 5'd5};
        vecs[2]  = '{1'b1, 3'd0, 1'b0, 32'h20,   32'hABCDEF80, 5'd3, 1'b1, 1'b0, 32'h0,        5'd0};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 32'h20,   32'h0,        5'd7, 1'b1, 1'b0, 32'hFFFFFF80, 5'd7};
        vecs[4]  = '{1'b0, 3'd0, 1'b0, 32'h20,   32'h0,        5'd8, 1'b1, 1'b0, 32'h00000080, 5'd8};
        vecs[5]  = '{1'b0, 3'd2, 1'b0, 32'h20,   32'h0,        5'd9, 1'b1, 1'b0, 32'h00000080, 5'd9};
        vecs[6]  = '{1'b0, 3'd2, 1'b0, 32'h1FFE, 32'h0,        5'd4, 1'b1, 1'b1, 32'h0,        5'd0};
        vecs[7]  = '{1'b1, 3'd1, 1'b0, 32'h30,   32'h12348001, 5'd1, 1'b1, 1'b0, 32'h0,        5'd0};
        vecs[8]  = '{1'b0, 3'd1, 1'b1, 32'h30,   32'h0,        5'd10, 1'b1, 1'b0, 32'hFFFF8001, 5'd10};
        vecs[9]  = '{1'b0, 3'd1, 1'b0, 32'h30,   32'h0,        5'd11, 1'b1, 1'b0, 32'h00008001, 5'd11};
        vecs[10] = '{1'b0, 3'd1, 1'b1, 32'h12,   32'h0,        5'd12, 1'b1, 1'b0, 32'h00001122, 5'd12};
        vecs[11] = '{1'b0, 3'd7, 1'b1, 32'h10,   32'h0,        5'd13, 1'b1, 1'b0, 32'h11223344, 5'd13};
        vecs[12] = '{1'b1, 3'd2, 1'b0, 32'h1FFC, 32'hDEADBEEF, 5'd2, 1'b1, 1'b0, 32'h0,        5'd0};
        vecs[13] = '{1'b0, 3'd0, 1'b1, 32'h1FFF, 32'h0,        5'd14, 1'b1, 1'b0, 32'hFFFFFFDE, 5'd14};
        vecs[14] = '{1'b0, 3'd0, 1'b0, 32'h2000, 32'h0,        5'd15, 1'b1, 1'b1, 32'h0,        5'd0};
        vecs[15] = '{1'b1, 3'd1, 1'b0, 32'h1FFF, 32'h5555,     5'd6, 1'b1, 1'b1, 32'h0,        5'd0};
        vecs[16] = '{1'b0, 3'd2, 1'b0, 32'h10,   32'h0,        5'd16, 1'b0, 1'b0, 32'h0,        5'd0};
        for (int i = 0; i < 17; i++) run_req($sformatf("vec%0d", i), vecs[i], 0);

        // Response held for five cycles of back-pressure.
        rv = '{1'b0, 3'd2, 1'b0, 32'h10, 32'h0, 5'd17, 1'b1, 1'b0, 32'h11223344, 5'd17};
        run_req("stall", rv, 5);

        // Half load at odd address: faults only when the misalign check is built in.
`ifdef LSU_MISALIGN_CHECK_EN
        rv = '{1'b0, 3'd1, 1'b0, 32'h21, 32'h0, 5'd18, 1'b1, 1'b1, 32'h0, 5'd0};
`else
        rv = '{1'b0, 3'd1, 1'b0, 32'h21, 32'h0, 5'd18, 1'b1, 1'b0, 32'h0, 5'd18};
`endif
        run_req("misalign", rv, 0);

        // Reset while in WAIT1: request abandoned, nothing ever returned.
        wait_ready("rst_mid");
        in_st = 1'b0; in_sz = 3'd2; in_sext = 1'b0; in_addr = 32'h10; in_rd = 5'd19;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("rst_mid_no_resp", seen, 0);
        end
        out_ready = 1'b0;

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [2:0] szs [4];
            int n, sel;
            szs[0] = 3'd0; szs[1] = 3'd1; szs[2] = 3'd2; szs[3] = 3'd7;
            rv.st    = 1'($urandom % 2);
            rv.sz    = szs[$urandom % 4];
            rv.sext  = 1'($urandom % 2);
            n = nbytes(rv.sz);
            sel = $urandom % 16;
            if (sel == 0)      rv.addr = 32'hFFFF_FFFC;
            else if (sel < 4)  rv.addr = 32'h1FF0 + 32'($urandom_range(0, 31));
            else               rv.addr = 32'($urandom % 256);
            rv.addr  = rv.addr & ~(32'(n) - 32'd1);
            rv.wdata = $urandom;
            rv.rd    = 5'($urandom_range(1, 31));
            rv.hit   = rv.st ? 1'b1 : 1'(($urandom % 8) != 0);
            rv.fault = model_fault(rv.addr, rv.sz);
            if (rv.st || rv.fault || !rv.hit) begin
                rv.exp_data = 32'd0; rv.exp_rd = 5'd0;
            end else begin
                rv.exp_data = model_load(rv.addr, rv.sz, rv.sext); rv.exp_rd = rv.rd;
            end
            run_req($sformatf("rand%0d", i), rv, $urandom_range(0, 2));
        end

        chk("re_we_overlap", both_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 8192, meaning data-memory size in bytes; accesses at or beyond it fault.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request valid from execute stage
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_st  in  1  1=store, 0=load
- in_sz  in  3  ACCESS_SZ_BYTE/HALF/WORD
- in_sext  in  1  sign-extend load result
- in_addr  in  32  byte address
- in_wdata  in  32  store data, right-justified
- in_rd  in  5  destination register
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts result
- out_data  out  32  extended load data; 0 for stores
- out_rd  out  5  echoed in_rd; 0 for stores and faults
- out_exc  out  1  access fault
- dc_re  out  1  dcache read enable
- dc_raddr  out  32  dcache read address
- dc_we  out  1  dcache write enable
- dc_waddr  out  32  dcache write address
- dc_wdata  out  32  dcache write data
- dc_wsz  out  3  dcache write size
- dc_rdata  in  32  dcache read data, two cycles after dc_re
- dc_hit  in  1  dcache hit, aligned with dc_rdata

Function
REQ-003 SHALL implement FSM states: IDLE, ISSUE, STORE, WAIT1, WAIT2, RESP.
REQ-004 in_ready SHALL be 1 only in IDLE; accepted request fields SHALL be registered at the accept edge.
REQ-005 Load accept SHALL go IDLE->ISSUE. ISSUE SHALL drive dc_re=1 and dc_raddr=addr for exactly one cycle, then go to WAIT1, then WAIT2.
REQ-006 WAIT2 SHALL capture dc_rdata/dc_hit at its end and go to RESP; total latency SHALL be accept edge + 4 cycles to out_valid.
REQ-007 Store accept SHALL go IDLE->STORE. STORE SHALL drive dc_we=1, dc_waddr, dc_wdata=in_wdata and dc_wsz=in_sz for exactly one cycle, then go to RESP.
REQ-008 RESP SHALL hold out_valid=1 with stable out_* until out_ready=1, then go to IDLE; no back-to-back accept in the same cycle.
REQ-009 Load extract: BYTE = dc_rdata[7:0] and HALF = dc_rdata[15:0], sign- or zero-extended per in_sext; WORD = dc_rdata unchanged.
REQ-010 A request with addr+size > MEM_BYTES SHALL skip dcache access (no dc_re/dc_we) and go directly to RESP with out_exc=1 and out_data=0.
REQ-011 A load returning dc_hit=0 SHALL give out_exc=1, out_data=0, out_rd=0.
REQ-012 dc_re and dc_we SHALL never both be 1; both SHALL be 0 outside ISSUE/STORE.
REQ-013 Store-then-load to the same address needs no forwarding: the RESP/IDLE gap guarantees dcache write completion before the next dc_re.
REQ-014 in_sz values other than BYTE/HALF SHALL be treated as WORD.

Reset
REQ-015 While rst=1 at an edge: state=IDLE; in_ready=1 after reset; out_valid, out_exc, dc_re, dc_we=0; out_data, out_rd, dc_* buses=0.
REQ-016 Reset mid-operation SHALL abandon the request, with no result produced; a dcache read already in flight SHALL be ignored.

Configuration
REQ-017 Macro LSU_MISALIGN_CHECK_EN: when defined, HALF with addr[0]!=0 or WORD with addr[1:0]!=0 SHALL fault as in REQ-010; when undefined, misaligned addresses SHALL pass to dcache unchanged.

Structure
REQ-018 ACCESS_SZ_* encodings SHALL come from the shared defs package; FSM encoding stays local.
REQ-019 Load extraction/extension SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-020 Word store 0x11223344 to 0x10, then word load from 0x10 -> out_data=0x11223344, out_exc=0, out_valid exactly 4 cycles after load accept.
REQ-021 Byte store 0x80 to 0x20, then byte loads with in_sext=1 and in_sext=0 -> 0xFFFFFF80 and 0x00000080.
REQ-022 Word load from 0x1FFE (MEM_BYTES=8192) -> out_exc=1, out_data=0, dc_re never asserted.
REQ-023 Load completes while out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout.
REQ-024 rst asserted in WAIT1 -> next cycle IDLE, out_valid=0, no response ever emitted.
REQ-025 With LSU_MISALIGN_CHECK_EN, half load from 0x21 -> out_exc=1; without it -> dc_re with dc_raddr=0x21.
